// File: rtl/perif_pkg.sv
// perif_handshake shared types and defaults.
// Holds the FSM state encoding and default parameter values.
package perif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } perif_state_e;

    localparam int PERIF_SYNC_STAGES_DEF = 2;
    localparam int PERIF_PROC_CYCLES_DEF = 3;

endpackage

// File: rtl/perif_sync.sv
// N-stage single-bit synchronizer with synchronous clear.
// Output is the last stage; stage 0 samples the raw input.
module perif_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q[0] <= i_d;
            for (int i = 1; i < N; i++) begin
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign o_q = r_q[N-1];

endmodule

// File: rtl/perif_handshake.sv
// Receiver side of a four-phase send/ack handshake.
// Synchronized send drives an IDLE/BUSY/ACK FSM with a registered ack.
module perif_handshake
    import perif_pkg::*;
#(
    parameter int SYNC_STAGES = PERIF_SYNC_STAGES_DEF,
    parameter int PROC_CYCLES = PERIF_PROC_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic send,
    output logic ack
);

    localparam int CNT_W =
        (PROC_CYCLES < 1) ? 1 : $clog2(PROC_CYCLES + 1);

    perif_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ack;
    logic             w_send_s;

    perif_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (send),
        .o_q (w_send_s)
    );

    // r_ack tracks the next state so ack is a pure flop output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_send_s && PROC_CYCLES == 0) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else if (w_send_s) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_W'(PROC_CYCLES - 1);
                        r_ack   <= 1'b0;
                    end else begin
                        r_ack   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (!w_send_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_ack   <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_ack   <= 1'b0;
                    end
                end
                ACK: begin
                    if (!w_send_s) begin
                        r_state <= IDLE;
                        r_ack   <= 1'b0;
                    end else begin
                        r_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign ack = r_ack;

endmodule

// File: tb/tb_perif_handshake.sv
// Scoreboard bench for perif_handshake (default and fast configs).
// Reference: ack is high once send_s has been seen high for P+1 edges.
module tb_perif_handshake;

    logic clk;
    logic rst;
    logic send;
    logic ack_def;
    logic ack_p0;

    localparam int NS [2] = '{2, 1};
    localparam int PS [2] = '{3, 0};

    perif_handshake u_def (
        .clk  (clk),
        .rst  (rst),
        .send (send),
        .ack  (ack_def)
    );

    perif_handshake #(
        .SYNC_STAGES (1),
        .PROC_CYCLES (0)
    ) u_p0 (
        .clk  (clk),
        .rst  (rst),
        .send (send),
        .ack  (ack_p0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit samp [2][$];
    int run  [2];
    bit exp_q0 [$];
    bit exp_q1 [$];
    int n_cmp;
    int n_bad;
    int cyc;
    bit done;

    // Expected ack after the coming edge for configuration i.
    task automatic model_edge(input int i, input bit r, input bit s,
                              output bit e);
        int n;
        int p;
        int sz;
        bit x;
        n = NS[i];
        p = PS[i];
        if (r) begin
            samp[i].push_back(1'b0);
            sz = samp[i].size();
            for (int k = 0; k < n && k < sz; k++) samp[i][sz-1-k] = 1'b0;
            run[i] = 0;
            e = 1'b0;
        end else begin
            sz = samp[i].size();
            x = (sz >= n) ? samp[i][sz-n] : 1'b0;
            samp[i].push_back(s);
            if (x) run[i] = (run[i] < 1000) ? run[i] + 1 : run[i];
            else   run[i] = 0;
            e = (run[i] >= p + 1);
        end
        if (samp[i].size() > 8) void'(samp[i].pop_front());
    endtask

    task automatic step(input bit r, input bit s);
        bit e0;
        bit e1;
        rst  = r;
        send = s;
        model_edge(0, r, s, e0);
        model_edge(1, r, s, e1);
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit e;
        cyc++;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            n_cmp++;
            if (ack_def !== e) begin
                n_bad++;
                $display("FAIL ack_def cyc=%0d got=%b exp=%b",
                         cyc, ack_def, e);
            end
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            n_cmp++;
            if (ack_p0 !== e) begin
                n_bad++;
                $display("FAIL ack_p0 cyc=%0d got=%b exp=%b",
                         cyc, ack_p0, e);
            end
        end
        if (done && (exp_q0.size() != 0 || exp_q1.size() != 0)) begin
            n_bad++;
            $display("FAIL drain cyc=%0d got=%0d exp=0 pending",
                     cyc, exp_q0.size() + exp_q1.size());
        end
    end

    initial begin
        bit lvl;
        bit r;
        int len;
        rst  = 1'b1;
        send = 1'b0;
        done = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        cyc  = 0;
        // reset held with send high, then full-latency rise
        repeat (3) step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        // abort during BUSY
        repeat (3) step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        // reset while ack high, send kept high
        repeat (8) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        // back-to-back with a one-cycle gap
        repeat (7) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        // random segments
        repeat (150) begin
            len = $urandom_range(1, 10);
            lvl = 1'($urandom_range(0, 1));
            repeat (len) begin
                r = ($urandom_range(0, 59) == 0);
                step(r, lvl);
            end
        end
        done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
